lstm_seq_ctrl: RTL and testbench

- Sequences one combinational lstm_cell instance over a sequence of seq_len timesteps.
- Per step: accepts X over a valid/ready stream, holds the recurrent c/h state in registers, drives the cell, waits CELL_LAT cycles for settling, captures c_out/h_out and emits h on an output stream.
- Sits between the input sample buffer and downstream consumers; the cell stays outside this block.

---
 rtl/lstm_pkg.sv | 17 +
 rtl/lstm_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// Shared defaults and the sequencer state encoding for the LSTM controller.
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;
  localparam int LSTM_SEQ_W       = 8;
  localparam int LSTM_CELL_LAT    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_EMIT,
    S_FIN
  } lstm_state_e;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Steps an external combinational lstm_cell over seq_len timesteps:
// takes one X per step, holds recurrent c/h, waits CELL_LAT cycles for the
// cell to settle, captures the results and streams h out.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH = LSTM_FRACT_WIDTH,
  parameter int SEQ_W       = LSTM_SEQ_W,
  parameter int CELL_LAT    = LSTM_CELL_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  keep_state,
  input  logic [SEQ_W-1:0]      seq_len,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic [DATA_WIDTH-1:0] h_init,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic [DATA_WIDTH-1:0] h_data,
  output logic                  h_valid,
  input  logic                  h_ready,
  output logic [SEQ_W-1:0]      step,
  output logic                  busy,
  output logic                  done
);

  // Q(INT).FRACT split kept only to document the fixed-point format of c/h.
  localparam int INT_WIDTH = DATA_WIDTH - FRACT_WIDTH;
  localparam int Q_WIDTH   = INT_WIDTH + FRACT_WIDTH;
  localparam int CNT_W     = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CELL_LAT - 1);

  lstm_state_e          state;
  logic [Q_WIDTH-1:0]   c_state;
  logic [Q_WIDTH-1:0]   h_state;
  logic [SEQ_W-1:0]     len_reg;
  logic [CNT_W-1:0]     cnt;

  assign cell_c = c_state;
  assign cell_h = h_state;

  // Sequencer FSM; every handshake/status output is a register updated
  // on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      c_state <= '0;
      h_state <= '0;
      len_reg <= '0;
      cnt     <= '0;
      cell_x  <= '0;
      h_data  <= '0;
      h_valid <= 1'b0;
      x_ready <= 1'b0;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!keep_state) begin
              c_state <= c_init;
              h_state <= h_init;
            end
            if (seq_len == '0) begin
              state <= S_FIN;
            end else begin
              state   <= S_LOAD;
              x_ready <= 1'b1;
              step    <= '0;
              len_reg <= seq_len;
            end
          end
        end
        S_LOAD: begin
          if (x_valid) begin
            cell_x  <= x_data;
            cnt     <= CNT_INIT;
            x_ready <= 1'b0;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (cnt == '0) begin
            c_state <= cell_c_out;
            h_state <= cell_h_out;
            h_data  <= cell_h_out;
            h_valid <= 1'b1;
            state   <= S_EMIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_EMIT: begin
          if (h_ready) begin
            h_valid <= 1'b0;
            if (step == len_reg - 1'b1) begin
              state <= S_FIN;
            end else begin
              step    <= step + 1'b1;
              x_ready <= 1'b1;
              state   <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with an adder-based cell stub.
module tb_lstm_seq_ctrl;

  localparam int DW  = 16;
  localparam int SW  = 8;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          keep_state;
  logic [SW-1:0] seq_len;
  logic [DW-1:0] c_init;
  logic [DW-1:0] h_init;
  logic [DW-1:0] x_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] cell_x;
  logic [DW-1:0] cell_c;
  logic [DW-1:0] cell_h;
  logic [DW-1:0] cell_c_out;
  logic [DW-1:0] cell_h_out;
  logic [DW-1:0] h_data;
  logic          h_valid;
  logic          h_ready;
  logic [SW-1:0] step;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  lstm_seq_ctrl #(
    .DATA_WIDTH (DW),
    .FRACT_WIDTH(8),
    .SEQ_W      (SW),
    .CELL_LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .keep_state(keep_state),
    .seq_len   (seq_len),
    .c_init    (c_init),
    .h_init    (h_init),
    .x_data    (x_data),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .cell_x    (cell_x),
    .cell_c    (cell_c),
    .cell_h    (cell_h),
    .cell_c_out(cell_c_out),
    .cell_h_out(cell_h_out),
    .h_data    (h_data),
    .h_valid   (h_valid),
    .h_ready   (h_ready),
    .step      (step),
    .busy      (busy),
    .done      (done)
  );

  // cell stub: c_out = c_in + x, h_out = h_in + 2x
  assign cell_c_out = cell_c + cell_x;
  assign cell_h_out = cell_h + (cell_x << 1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_x_ready"}, 32'(x_ready), 32'd0);
    chk({tag, "_h_valid"}, 32'(h_valid), 32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_step"},    32'(step),    32'd0);
    chk({tag, "_h_data"},  32'(h_data),  32'd0);
    chk({tag, "_cell_x"},  32'(cell_x),  32'd0);
    chk({tag, "_cell_c"},  32'(cell_c),  32'd0);
    chk({tag, "_cell_h"},  32'(cell_h),  32'd0);
  endtask

  task automatic start_seq(input logic keep, input logic [SW-1:0] len,
                           input logic [DW-1:0] c0, input logic [DW-1:0] h0);
    start = 1'b1; keep_state = keep; seq_len = len; c_init = c0; h_init = h0;
    @(negedge clk);
    start = 1'b0;
    // values changing while busy must be ignored
    seq_len = 8'hFF; c_init = 16'h7777; h_init = 16'h5555; keep_state = ~keep;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // one timestep: offer x, check latency/result, optionally stall h_ready
  task automatic do_step(input logic [DW-1:0] x, input logic [DW-1:0] exp_h,
                         input logic [SW-1:0] exp_step, input int hold);
    int acc;
    logic [DW-1:0] held;
    x_data = x; x_valid = 1'b1;
    for (int k = 0; k < 20 && !x_ready; k++) @(negedge clk);
    chk("x_ready_wait", 32'(x_ready), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    x_data = 16'hDEAD;
    for (int k = 0; k < 20 && !h_valid; k++) @(negedge clk);
    chk("h_valid_wait", 32'(h_valid), 32'd1);
    chk("h_latency", 32'(cyc), 32'(acc + LAT));
    chk("h_data", 32'(h_data), 32'(exp_h));
    chk("step", 32'(step), 32'(exp_step));
    chk("cell_x_hold", 32'(cell_x), 32'(x));
    chk("x_ready_emit", 32'(x_ready), 32'd0);
    if (hold > 0) begin
      h_ready = 1'b0;
      held = h_data;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_h_data", 32'(h_data), 32'(held));
        chk("hold_h_valid", 32'(h_valid), 32'd1);
        chk("hold_x_ready", 32'(x_ready), 32'd0);
        chk("hold_step", 32'(step), 32'(exp_step));
      end
      h_ready = 1'b1;
    end
    @(negedge clk);
    chk("h_valid_drop", 32'(h_valid), 32'd0);
  endtask

  task automatic wait_done(input int exp_pulses_before);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    chk("done_seen", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(exp_pulses_before + 1));
  endtask

  task automatic scenario_basic();
    int d0;
    d0 = done_cnt;
    start_seq(1'b0, 8'd3, 16'h0010, 16'h0020);
    do_step(16'h0001, 16'h0022, 8'd0, 0);
    do_step(16'h0002, 16'h0026, 8'd1, 0);
    do_step(16'h0003, 16'h002C, 8'd2, 0);
    wait_done(d0);
    chk("final_c", 32'(cell_c), 32'h0016);
    chk("final_h", 32'(cell_h), 32'h002C);
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b1; keep_state = 1'b0; seq_len = 8'd3;
    c_init = 16'h1234; h_init = 16'h4321; x_data = 16'h0009;
    x_valid = 1'b1; h_ready = 1'b1;

    // reset held with start asserted
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    // three-step sequence from explicit initial state
    scenario_basic();

    // keep_state restart continues from the retained c/h
    d0 = done_cnt;
    start_seq(1'b1, 8'd1, 16'h0BAD, 16'h0BAD);
    do_step(16'h0001, 16'h002E, 8'd0, 0);
    wait_done(d0);
    chk("keep_c", 32'(cell_c), 32'h0017);

    // zero-length sequence: straight to done, no handshakes
    d0 = done_cnt;
    start_seq(1'b0, 8'd0, 16'h0000, 16'h0000);
    chk("len0_c1_done", 32'(done), 32'd0);
    chk("len0_c1_x_ready", 32'(x_ready), 32'd0);
    chk("len0_c1_h_valid", 32'(h_valid), 32'd0);
    @(negedge clk);
    chk("len0_c2_done", 32'(done), 32'd1);
    chk("len0_c2_x_ready", 32'(x_ready), 32'd0);
    chk("len0_c2_h_valid", 32'(h_valid), 32'd0);
    @(negedge clk);
    chk("len0_c3_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("len0_count", 32'(done_cnt), 32'(d0 + 1));

    // back-pressure on step 0
    d0 = done_cnt;
    start_seq(1'b0, 8'd2, 16'h0000, 16'h0000);
    do_step(16'h0005, 16'h000A, 8'd0, 5);
    do_step(16'h0006, 16'h0016, 8'd1, 0);
    wait_done(d0);
    chk("bp_c", 32'(cell_c), 32'h000B);

    // reset during EVAL of step 1 aborts without done
    d0 = done_cnt;
    start_seq(1'b0, 8'd3, 16'h0010, 16'h0020);
    do_step(16'h0001, 16'h0022, 8'd0, 0);
    x_data = 16'h0002;
    for (int k = 0; k < 20 && !x_ready; k++) @(negedge clk);
    chk("abort_x_ready", 32'(x_ready), 32'd1);
    @(negedge clk);
    chk("abort_in_eval_busy", 32'(busy), 32'd1);
    chk("abort_in_eval_cell_x", 32'(cell_x), 32'h0002);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle_zero("abort");
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // fresh run after abort matches the basic scenario
    scenario_basic();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
